// File: rtl/light_show_ctrl.sv
// Light-show controller: injects a light on a synchronized fire edge and
// shifts/rotates the pattern at a programmable prescaled rate.
module light_show_ctrl #(
  parameter int WIDTH = 10,
  parameter int BASE  = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_fire,
  input  logic             key_clear,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] lights,
  output logic             step,
  output logic             running
);

  localparam int PW = BASE + 3;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic             fire_m_q, fire_s_q, fire_p_q;
  logic             clear_m_q, clear_s_q;
  logic [PW-1:0]    presc_q, presc_d, tc;
  logic [WIDTH-1:0] lights_q, lights_d, shifted;
  logic             step_q, step_d;
  logic             pend_q, pend_d;
  logic             fire_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fire_m_q  <= 1'b0;
      fire_s_q  <= 1'b0;
      fire_p_q  <= 1'b0;
      clear_m_q <= 1'b0;
      clear_s_q <= 1'b0;
    end else begin
      fire_m_q  <= key_fire;
      fire_s_q  <= fire_m_q;
      fire_p_q  <= fire_s_q;
      clear_m_q <= key_clear;
      clear_s_q <= clear_m_q;
    end
  end

  assign fire_edge = fire_s_q & ~fire_p_q;
  // All-ones shifted down leaves 2^(BASE+speed)-1.
  assign tc = {PW{1'b1}} >> (2'd3 - speed);

  always_comb begin
    shifted = '0;
    case (mode)
      2'b00:   shifted = {fire_s_q, lights_q[WIDTH-1:1]};
      2'b01:   shifted = {lights_q[WIDTH-2:0], fire_s_q};
      2'b10:   shifted = {lights_q[0] | pend_q, lights_q[WIDTH-1:1]};
      default: shifted = {lights_q[WIDTH-2:0], lights_q[WIDTH-1] | pend_q};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    presc_d  = presc_q;
    pend_d   = pend_q;
    step_d   = 1'b0;
    if (clear_s_q) begin
      state_d  = IDLE;
      lights_d = '0;
      presc_d  = '0;
      pend_d   = 1'b0;
    end else if (state_q == IDLE) begin
      lights_d = '0;
      presc_d  = '0;
      pend_d   = 1'b0;
      if (fire_edge) begin
        state_d = RUN;
        if (mode[0]) lights_d[0] = 1'b1;
        else         lights_d[WIDTH-1] = 1'b1;
      end
    end else begin
      // >= rather than == so a mid-count speed decrease steps at once.
      if (presc_q >= tc) begin
        step_d   = 1'b1;
        presc_d  = '0;
        lights_d = shifted;
        pend_d   = fire_edge;
        if (shifted == '0) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end
      end else begin
        presc_d = presc_q + 1'b1;
        if (fire_edge) pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lights_q <= '0;
      presc_q  <= '0;
      pend_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      presc_q  <= presc_d;
      pend_q   <= pend_d;
      step_q   <= step_d;
    end
  end

  assign lights  = lights_q;
  assign step    = step_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_light_show_ctrl.sv
// Directed bench for light_show_ctrl (WIDTH=10, BASE=2) with a queue-based
// scoreboard of per-cycle expected lights/step/running.
module tb_light_show_ctrl;

  logic       clk;
  logic       reset_n;
  logic       key_fire;
  logic       key_clear;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [9:0] lights;
  logic       step;
  logic       running;

  typedef struct {
    string      tag;
    logic [9:0] l;
    logic       s;
    logic       r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  light_show_ctrl #(.WIDTH(10), .BASE(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_fire  (key_fire),
    .key_clear (key_clear),
    .mode      (mode),
    .speed     (speed),
    .lights    (lights),
    .step      (step),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string tag, input logic [9:0] l, input logic s, input logic r);
    exp_t e;
    e.tag = tag;
    e.l   = l;
    e.s   = s;
    e.r   = r;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty");
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert ({lights, step, running} === {e.l, e.s, e.r}) else begin
        errors++;
        $error("FAIL %s observed lights=%h step=%b running=%b expected lights=%h step=%b running=%b",
               e.tag, lights, step, running, e.l, e.s, e.r);
      end
    end
  endtask

  // Drive inputs for the next edge, record the expected post-edge outputs, then compare.
  task automatic cyc(input logic f, input logic c, input logic [9:0] l, input logic s,
                     input logic r, input string tag);
    key_fire  = f;
    key_clear = c;
    push_exp(tag, l, s, r);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic hold(input int unsigned n, input logic f, input logic c, input logic [9:0] l,
                      input logic r, input string tag);
    for (int unsigned i = 0; i < n; i++) cyc(f, c, l, 1'b0, r, tag);
  endtask

  logic [9:0] v;

  initial begin
    reset_n   = 1'b0;
    key_fire  = 1'b0;
    key_clear = 1'b0;
    mode      = 2'b00;
    speed     = 2'b00;
    #3;
    push_exp("reset_state", 10'h000, 1'b0, 1'b0);
    check_out();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Shift-right, speed 0, 3-cycle fire pulse: walks MSB down to zero.
    mode = 2'b00; speed = 2'd0;
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, "A_sync1");
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, "A_sync2");
    cyc(1'b1, 1'b0, 10'h200, 1'b0, 1'b1, "A_entry");
    v = 10'h200;
    for (int k = 1; k <= 10; k++) begin
      hold(3, 1'b0, 1'b0, v, 1'b1, "A_hold");
      v = v >> 1;
      cyc(1'b0, 1'b0, v, 1'b1, (v != 10'h000), "A_step");
    end
    hold(2, 1'b0, 1'b0, 10'h000, 1'b0, "A_idle");

    // Shift-left with fire held: LSB entry, fire_s shifted in on first step.
    mode = 2'b01;
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, "G_sync1");
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, "G_sync2");
    cyc(1'b1, 1'b0, 10'h001, 1'b0, 1'b1, "G_entry");
    hold(3, 1'b1, 1'b0, 10'h001, 1'b1, "G_hold");
    cyc(1'b0, 1'b0, 10'h003, 1'b1, 1'b1, "G_step_fire_in");
    v = 10'h003;
    for (int k = 1; k <= 10; k++) begin
      hold(3, 1'b0, 1'b0, v, 1'b1, "G_hold");
      v = {v[8:0], 1'b0};
      cyc(1'b0, 1'b0, v, 1'b1, (v != 10'h000), "G_step");
    end
    hold(2, 1'b0, 1'b0, 10'h000, 1'b0, "G_idle");

    // Rotate-right, speed 1: single light circulates with wrap, never stops.
    mode = 2'b10; speed = 2'd1;
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, "B_sync1");
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, "B_sync2");
    cyc(1'b0, 1'b0, 10'h200, 1'b0, 1'b1, "B_entry");
    v = 10'h200;
    for (int k = 1; k <= 12; k++) begin
      hold(7, 1'b0, 1'b0, v, 1'b1, "B_hold");
      v = {v[0], v[9:1]};
      cyc(1'b0, 1'b0, v, 1'b1, 1'b1, "B_step");
    end

    // Rotate-left at speed 0, mid-period inject lands on exactly one step.
    mode = 2'b11; speed = 2'd0;
    hold(3, 1'b0, 1'b0, v, 1'b1, "C_hold");
    v = {v[8:0], v[9]};
    cyc(1'b0, 1'b0, v, 1'b1, 1'b1, "C_mode_change_step");
    cyc(1'b1, 1'b0, v, 1'b0, 1'b1, "C_fire");
    hold(2, 1'b0, 1'b0, v, 1'b1, "C_hold");
    cyc(1'b0, 1'b0, 10'h201, 1'b1, 1'b1, "C_inject_step");
    hold(3, 1'b0, 1'b0, 10'h201, 1'b1, "C_hold");
    cyc(1'b0, 1'b0, 10'h003, 1'b1, 1'b1, "C_after_inject");
    hold(3, 1'b0, 1'b0, 10'h003, 1'b1, "C_hold");
    cyc(1'b0, 1'b0, 10'h006, 1'b1, 1'b1, "C_pend_cleared");

    // Clear while rotating with fire held; fire must be ignored.
    cyc(1'b1, 1'b1, 10'h006, 1'b0, 1'b1, "D_clear_sync1");
    cyc(1'b1, 1'b1, 10'h006, 1'b0, 1'b1, "D_clear_sync2");
    cyc(1'b1, 1'b1, 10'h000, 1'b0, 1'b0, "D_cleared");
    hold(3, 1'b1, 1'b1, 10'h000, 1'b0, "D_clear_held");
    hold(5, 1'b0, 1'b0, 10'h000, 1'b0, "D_idle_after");

    // Speed 3 -> 0 with prescaler at 20: immediate step then 4-cycle period.
    mode = 2'b10; speed = 2'd3;
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, "E_sync1");
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, "E_sync2");
    cyc(1'b0, 1'b0, 10'h200, 1'b0, 1'b1, "E_entry");
    hold(20, 1'b0, 1'b0, 10'h200, 1'b1, "E_slow_hold");
    speed = 2'd0;
    cyc(1'b0, 1'b0, 10'h100, 1'b1, 1'b1, "E_speed_drop_step");
    hold(3, 1'b0, 1'b0, 10'h100, 1'b1, "E_hold");
    cyc(1'b0, 1'b0, 10'h080, 1'b1, 1'b1, "E_fast_step");

    // Pending inject armed, then asynchronous reset mid-RUN.
    cyc(1'b1, 1'b0, 10'h080, 1'b0, 1'b1, "F_fire");
    hold(2, 1'b0, 1'b0, 10'h080, 1'b1, "F_hold");
    reset_n = 1'b0;
    #1;
    push_exp("F_async_reset", 10'h000, 1'b0, 1'b0);
    check_out();
    hold(2, 1'b0, 1'b0, 10'h000, 1'b0, "F_in_reset");
    reset_n = 1'b1;
    hold(5, 1'b0, 1'b0, 10'h000, 1'b0, "F_idle_after_reset");
    cyc(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, "F_sync1");
    cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, "F_sync2");
    cyc(1'b0, 1'b0, 10'h200, 1'b0, 1'b1, "F_reentry");
    hold(3, 1'b0, 1'b0, 10'h200, 1'b1, "F_hold");
    cyc(1'b0, 1'b0, 10'h100, 1'b1, 1'b1, "F_no_residual_pend");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
